// File: rtl/uart_pico.sv
// uart_pico: memory-mapped 8N1 UART (TX + RX) for the PicoRV32 native bus.
// The TX data register and the RX data register are single-word slaves; each
// access hit is acknowledged with a one-cycle ready. The line rate is set at run
// time in clock cycles per bit. Both directions raise level interrupt flags.
module uart_pico #(
  parameter logic [31:0] TX_ADDR = 32'hcaca_bebe,
  parameter logic [31:0] RX_ADDR = 32'hcafe_babe
) (
  input  logic        clk,
  input  logic        rstn,            // active-high despite the name
  input  logic [11:0] clk_per_bit,
  input  logic [31:0] addr,
  input  logic        mem_valid,
  input  logic        wstrobe,
  input  logic [7:0]  wdata,
  input  logic        mem_ready,
  input  logic        rx_uart,
  output logic        tx_uart,
  output logic        uart_tx_ready,
  output logic        uart_tx_int_flag,
  output logic [7:0]  data_out,
  output logic        uart_rx_ready,
  output logic        uart_rx_int_flag
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  // A hit is accepted only while no slave is answering. This stops a request
  // that is still held valid from being accepted a second time.
  logic tx_hit, rx_hit;
  assign tx_hit = mem_valid &  wstrobe & (addr == TX_ADDR) & ~mem_ready;
  assign rx_hit = mem_valid & ~wstrobe & (addr == RX_ADDR) & ~mem_ready;

  // ---------------- transmitter state ----------------
  state_e      tx_state_q, tx_state_d;
  logic [11:0] tx_cnt_q,   tx_cnt_d;
  logic [2:0]  tx_bit_q,   tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        tx_line_q,  tx_line_d;
  logic        tx_flag_q,  tx_flag_d;
  logic        tx_ready_q, tx_ready_d;

  // ---------------- receiver state ----------------
  logic        rx_sync1_q, rx_sync2_q, rx_prev_q;
  state_e      rx_state_q, rx_state_d;
  logic [11:0] rx_cnt_q,   rx_cnt_d;
  logic [2:0]  rx_bit_q,   rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  rx_data_q,  rx_data_d;
  logic        rx_flag_q,  rx_flag_d;
  logic        rx_ready_q, rx_ready_d;
  logic        rx_fall, rx_done;

  logic [11:0] bit_last, half_last;
  assign bit_last  = clk_per_bit - 12'd1;
  assign half_last = {1'b0, clk_per_bit[11:1]} - 12'd1;

  // TX next state: the line level is registered so tx_uart is glitch-free.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = tx_line_q;
    tx_flag_d  = tx_flag_q;
    tx_ready_d = tx_hit;   // writes while busy are acknowledged but dropped
    unique case (tx_state_q)
      S_IDLE: begin
        if (tx_hit) begin
          tx_shift_d = wdata;
          tx_flag_d  = 1'b0;
          tx_cnt_d   = bit_last;
          tx_line_d  = 1'b0;
          tx_state_d = S_START;
        end
      end
      S_START: begin
        if (tx_cnt_q == 12'd0) begin
          tx_cnt_d   = bit_last;
          tx_bit_d   = 3'd0;
          tx_line_d  = tx_shift_q[0];
          tx_state_d = S_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q - 12'd1;
        end
      end
      S_DATA: begin
        if (tx_cnt_q == 12'd0) begin
          tx_cnt_d = bit_last;
          if (tx_bit_q == 3'd7) begin
            tx_line_d  = 1'b1;
            tx_state_d = S_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_line_d  = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 12'd1;
        end
      end
      S_STOP: begin
        if (tx_cnt_q == 12'd0) begin
          tx_flag_d  = 1'b1;
          tx_state_d = S_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q - 12'd1;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  // TX state register; reset aborts any frame and returns the line to idle.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_line_q  <= 1'b1;
      tx_flag_q  <= 1'b0;
      tx_ready_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments in clocked blocks, so every flop
      // samples values from before the edge regardless of statement order.
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
      tx_flag_q  <= tx_flag_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  // Falling edge of the synchronized line marks a possible start bit.
  assign rx_fall = rx_prev_q & ~rx_sync2_q;

  // RX next state: sample at bit centres, half a bit after the falling edge.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_done    = 1'b0;
    rx_ready_d = rx_hit;
    unique case (rx_state_q)
      S_IDLE: begin
        if (rx_fall) begin
          rx_cnt_d   = half_last;
          rx_state_d = S_START;
        end
      end
      S_START: begin
        if (rx_cnt_q == 12'd0) begin
          if (rx_sync2_q) begin
            rx_state_d = S_IDLE;           // too short to be a start bit
          end else begin
            rx_cnt_d   = bit_last;
            rx_bit_d   = 3'd0;
            rx_state_d = S_DATA;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 12'd1;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == 12'd0) begin
          rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
          rx_cnt_d   = bit_last;
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q - 12'd1;
        end
      end
      S_STOP: begin
        if (rx_cnt_q == 12'd0) begin
          if (rx_sync2_q) begin            // framing error drops the byte
            rx_data_d = rx_shift_q;
            rx_done   = 1'b1;
          end
          rx_state_d = S_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q - 12'd1;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
    // A read clears the flag, but a frame completing in the same cycle wins.
    rx_flag_d = rx_flag_q;
    if (rx_hit)  rx_flag_d = 1'b0;
    if (rx_done) rx_flag_d = 1'b1;
  end

  // RX synchronizer and state register; the line history resets to idle-high.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_flag_q  <= 1'b0;
      rx_ready_q <= 1'b0;
    end else begin
      rx_sync1_q <= rx_uart;
      rx_sync2_q <= rx_sync1_q;
      rx_prev_q  <= rx_sync2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_flag_q  <= rx_flag_d;
      rx_ready_q <= rx_ready_d;
    end
  end

  assign tx_uart          = tx_line_q;
  assign uart_tx_ready    = tx_ready_q;
  assign uart_tx_int_flag = tx_flag_q;
  assign data_out         = rx_data_q;
  assign uart_rx_ready    = rx_ready_q;
  assign uart_rx_int_flag = rx_flag_q;

endmodule

// File: tb/tb_uart_pico.sv
// Testbench for uart_pico: directed bus accesses and serial frames, with
// expected bytes queued at stimulus time and checked by independent monitors
// of the TX line and of the received-data outputs.
module tb_uart_pico;

  localparam logic [31:0] TX_A = 32'hcaca_bebe;
  localparam logic [31:0] RX_A = 32'hcafe_babe;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [11:0] cpb = 12'd1666;
  logic [31:0] addr = '0;
  logic        mem_valid = 1'b0;
  logic        wstrobe = 1'b0;
  logic [7:0]  wdata = '0;
  logic        mem_ready;
  logic        rx_uart;
  logic        tx_uart, uart_tx_ready, uart_tx_int_flag;
  logic [7:0]  data_out;
  logic        uart_rx_ready, uart_rx_int_flag;

  logic loop_en = 1'b0;
  logic rx_drv  = 1'b1;
  logic mon_en  = 1'b0;

  int total = 0;
  int bad   = 0;
  int tx_rdy_cnt = 0;
  int rx_rdy_cnt = 0;

  logic [7:0] exp_tx_q[$];
  logic [7:0] exp_rx_q[$];

  assign mem_ready = uart_tx_ready | uart_rx_ready;
  assign rx_uart   = loop_en ? tx_uart : rx_drv;

  always #5 clk = ~clk;

  uart_pico dut (
    .clk              (clk),
    .rstn             (rstn),
    .clk_per_bit      (cpb),
    .addr             (addr),
    .mem_valid        (mem_valid),
    .wstrobe          (wstrobe),
    .wdata            (wdata),
    .mem_ready        (mem_ready),
    .rx_uart          (rx_uart),
    .tx_uart          (tx_uart),
    .uart_tx_ready    (uart_tx_ready),
    .uart_tx_int_flag (uart_tx_int_flag),
    .data_out         (data_out),
    .uart_rx_ready    (uart_rx_ready),
    .uart_rx_int_flag (uart_rx_int_flag)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Ready pulse counter, sampled on the falling edge.
  always @(negedge clk) begin
    if (uart_tx_ready === 1'b1) tx_rdy_cnt++;
    if (uart_rx_ready === 1'b1) rx_rdy_cnt++;
  end

  // Line monitor: decodes each frame on tx_uart at bit centres.
  initial begin : line_mon
    logic       prev;
    logic [9:0] frame;
    logic [7:0] b;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_uart === 1'b0 && prev === 1'b1) begin
        repeat (int'(cpb) / 2 - 1) @(negedge clk);
        frame[0] = tx_uart;
        for (int i = 1; i < 10; i++) begin
          repeat (int'(cpb)) @(negedge clk);
          frame[i] = tx_uart;
        end
        if (mon_en) begin
          if (exp_tx_q.size() == 0) begin
            check("tx_unexpected_frame", {22'd0, frame}, 32'h0);
          end else begin
            b = exp_tx_q.pop_front();
            check("tx_line_frame", {22'd0, frame}, {22'd0, 1'b1, b, 1'b0});
          end
        end
      end
      prev = tx_uart;
    end
  end

  // Receive monitor: a flag rise or a data change is one received byte.
  initial begin : rx_mon
    logic       pflag;
    logic [7:0] pdata;
    logic [7:0] b;
    pflag = 1'b0;
    pdata = 8'h00;
    forever begin
      @(negedge clk);
      if (mon_en && ((uart_rx_int_flag === 1'b1 && pflag === 1'b0) || data_out !== pdata)) begin
        if (exp_rx_q.size() == 0) begin
          check("rx_unexpected_byte", {24'd0, data_out}, 32'h0);
        end else begin
          b = exp_rx_q.pop_front();
          check("rx_data_out", {24'd0, data_out}, {24'd0, b});
          check("rx_flag_on_update", {31'd0, uart_rx_int_flag}, 32'd1);
        end
      end
      pflag = uart_rx_int_flag;
      pdata = data_out;
    end
  end

  // One bus access held valid for two cycles, then the ready pulses are counted.
  task automatic bus_access(input logic [31:0] a, input logic we, input logic [7:0] d,
                            input int exp_tx, input int exp_rx, input string name);
    @(negedge clk);
    tx_rdy_cnt = 0;
    rx_rdy_cnt = 0;
    addr = a; wstrobe = we; wdata = d; mem_valid = 1'b1;
    repeat (2) @(negedge clk);
    mem_valid = 1'b0; wstrobe = 1'b0; addr = '0;
    repeat (2) @(negedge clk);
    check({name, "_tx_ready_pulses"}, tx_rdy_cnt, exp_tx);
    check({name, "_rx_ready_pulses"}, rx_rdy_cnt, exp_rx);
  endtask

  // Bounded wait for a flag: sel 0 = TX flag, 1 = RX flag.
  task automatic wait_until(input int sel, input int budget, input string name);
    int  n;
    logic v;
    n = 0;
    v = (sel == 0) ? uart_tx_int_flag : uart_rx_int_flag;
    while (v !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
      v = (sel == 0) ? uart_tx_int_flag : uart_rx_int_flag;
    end
    if (v !== 1'b1) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Drives one serial frame on rx_uart directly (loopback must be off).
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = f[i];
      repeat (int'(cpb)) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check("rst_tx_uart", {31'd0, tx_uart}, 32'd1);
    check("rst_tx_ready", {31'd0, uart_tx_ready}, 32'd0);
    check("rst_rx_ready", {31'd0, uart_rx_ready}, 32'd0);
    check("rst_tx_flag", {31'd0, uart_tx_int_flag}, 32'd0);
    check("rst_rx_flag", {31'd0, uart_rx_int_flag}, 32'd0);
    check("rst_data_out", {24'd0, data_out}, 32'h00);
    mon_en = 1'b1;

    // Loopback of AF at 1666 cycles per bit
    loop_en = 1'b1;
    exp_tx_q.push_back(8'hAF);
    exp_rx_q.push_back(8'hAF);
    bus_access(TX_A, 1'b1, 8'hAF, 1, 0, "wr_af");
    check("af_line_low_start", {31'd0, tx_uart}, 32'd0);
    check("af_tx_flag_clear", {31'd0, uart_tx_int_flag}, 32'd0);
    wait_until(1, 11 * 1666, "af_rx_flag");
    wait_until(0, 2 * 1666, "af_tx_flag");
    check("af_tx_flag_set", {31'd0, uart_tx_int_flag}, 32'd1);
    check("af_rx_flag_set", {31'd0, uart_rx_int_flag}, 32'd1);

    // Read acknowledges and clears the RX flag, data held
    bus_access(RX_A, 1'b0, 8'h00, 0, 1, "rd_af");
    check("rd_rx_flag_clear", {31'd0, uart_rx_int_flag}, 32'd0);
    check("rd_data_kept", {24'd0, data_out}, 32'hAF);

    // Faster rate: loopback EE; TX flag stays clear until its frame ends
    repeat (4) @(negedge clk);
    cpb = 12'd16;
    exp_tx_q.push_back(8'hEE);
    exp_rx_q.push_back(8'hEE);
    bus_access(TX_A, 1'b1, 8'hEE, 1, 0, "wr_ee");
    check("ee_tx_flag_cleared", {31'd0, uart_tx_int_flag}, 32'd0);
    wait_until(1, 12 * 16, "ee_rx_flag");
    check("ee_tx_flag_still_clear", {31'd0, uart_tx_int_flag}, 32'd0);
    wait_until(0, 3 * 16, "ee_tx_flag");

    // Write during an active frame is acked and dropped; overrun keeps flag
    exp_tx_q.push_back(8'h3C);
    exp_rx_q.push_back(8'h3C);
    bus_access(TX_A, 1'b1, 8'h3C, 1, 0, "wr_3c");
    repeat (40) @(negedge clk);
    bus_access(TX_A, 1'b1, 8'h55, 1, 0, "wr_55_busy");
    wait_until(0, 12 * 16, "3c_tx_flag");
    repeat (15 * 16) @(negedge clk);
    check("busy_tx_queue_empty", exp_tx_q.size(), 32'd0);
    check("busy_rx_queue_empty", exp_rx_q.size(), 32'd0);
    check("overrun_data", {24'd0, data_out}, 32'h3C);
    bus_access(RX_A, 1'b0, 8'h00, 0, 1, "rd_3c");
    check("rd_3c_flag_clear", {31'd0, uart_rx_int_flag}, 32'd0);

    // Start-bit glitch of 100 cycles at 1666 cycles per bit
    loop_en = 1'b0;
    cpb = 12'd1666;
    rx_drv = 1'b0;
    repeat (100) @(negedge clk);
    rx_drv = 1'b1;
    repeat (1000) @(negedge clk);
    check("glitch_rx_flag", {31'd0, uart_rx_int_flag}, 32'd0);
    check("glitch_data_kept", {24'd0, data_out}, 32'h3C);

    // Framing error is discarded; a following good frame is received
    cpb = 12'd16;
    send_frame(8'h12, 1'b0);
    repeat (3 * 16) @(negedge clk);
    check("frame_err_rx_flag", {31'd0, uart_rx_int_flag}, 32'd0);
    check("frame_err_data_kept", {24'd0, data_out}, 32'h3C);
    exp_rx_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    wait_until(1, 4 * 16, "81_rx_flag");
    bus_access(RX_A, 1'b0, 8'h00, 0, 1, "rd_81");

    // Minimum rate of 4 cycles per bit
    repeat (4) @(negedge clk);
    cpb = 12'd4;
    loop_en = 1'b1;
    exp_tx_q.push_back(8'hC3);
    exp_rx_q.push_back(8'hC3);
    bus_access(TX_A, 1'b1, 8'hC3, 1, 0, "wr_c3");
    wait_until(0, 12 * 4, "c3_tx_flag");
    wait_until(1, 4 * 4, "c3_rx_flag");
    repeat (8) @(negedge clk);

    // Accesses that do not hit
    bus_access(32'h0, 1'b1, 8'h77, 0, 0, "wr_addr0");
    bus_access(32'h0, 1'b0, 8'h00, 0, 0, "rd_addr0");
    bus_access(RX_A, 1'b1, 8'h77, 0, 0, "wr_rx_addr");
    bus_access(TX_A, 1'b0, 8'h00, 0, 0, "rd_tx_addr");
    check("miss_tx_flag_kept", {31'd0, uart_tx_int_flag}, 32'd1);

    // Reset in the middle of a frame
    check("end_tx_queue_empty", exp_tx_q.size(), 32'd0);
    check("end_rx_queue_empty", exp_rx_q.size(), 32'd0);
    cpb = 12'd16;
    bus_access(TX_A, 1'b1, 8'h00, 1, 0, "wr_abort");
    mon_en = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_line_low", {31'd0, tx_uart}, 32'd0);
    rstn = 1'b1;
    #1;
    check("abort_line_idle", {31'd0, tx_uart}, 32'd1);
    check("abort_data_reset", {24'd0, data_out}, 32'h00);
    check("abort_rx_flag_reset", {31'd0, uart_rx_int_flag}, 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    repeat (20 * 16) @(negedge clk);
    check("abort_no_tx_flag", {31'd0, uart_tx_int_flag}, 32'd0);
    check("abort_line_stays_idle", {31'd0, tx_uart}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_pico.md
# uart_pico

Memory-mapped 8N1 UART (transmitter plus receiver) attached to the PicoRV32 native memory bus as two single-word peripheral slaves. A store to the TX address launches one serial frame on `tx_uart`. A load from the RX address acknowledges the last received byte, which is presented on `data_out`. Both directions raise level interrupt flags for the CPU's IRQ logic; the baud rate is run-time programmable in clock cycles per bit.

## Interface
- `TX_ADDR`, default 32'hcaca_bebe: bus address of the transmit data register.
- `RX_ADDR`, default 32'hcafe_babe: bus address of the receive data register.

Clock and reset: one clock; reset is asynchronous and active-high.

- `clk` in 1: system clock (16 MHz nominal).
- `rstn` in 1: asynchronous, active-high reset (`rstn`=1 resets).
- `clk_per_bit` in 12: clock cycles per serial bit (16 MHz/9600 = 1666); minimum 4; changed only while both directions are idle.
- `addr` in 32: bus address.
- `mem_valid` in 1: bus request valid.
- `wstrobe` in 1: 1 = write request, 0 = read request.
- `wdata` in 8: byte to transmit (bus wdata[7:0]).
- `mem_ready` in 1: system-wide bus ready (OR of all slave readies, including this block's).
- `rx_uart` in 1: serial input, idle high.
- `tx_uart` out 1: serial output, idle high.
- `uart_tx_ready` out 1: one-cycle acknowledge of a TX write.
- `uart_tx_int_flag` out 1: transmit-complete flag.
- `data_out` out 8: last correctly received byte.
- `uart_rx_ready` out 1: one-cycle acknowledge of an RX read.
- `uart_rx_int_flag` out 1: byte-received flag.

## Operation
- Reset values:
  - `tx_uart`=1.
  - `uart_tx_ready`, `uart_rx_ready`, `uart_tx_int_flag`, `uart_rx_int_flag` = 0.
  - `data_out`=8'h00.
  - Both FSMs at IDLE.
- Reset mid-frame aborts the frame immediately.

Bus acceptance:
- TX write hit: `mem_valid` & `wstrobe` & `addr`==`TX_ADDR` & !`mem_ready`.
- RX read hit: `mem_valid` & !`wstrobe` & `addr`==`RX_ADDR` & !`mem_ready`.
- A hit registers the corresponding ready high for exactly one cycle. The `!mem_ready` term prevents a second acceptance while `mem_valid` is still held.
- Non-matching addresses are ignored entirely.

TX FSM (IDLE, START, DATA, STOP):
- TX write hit in IDLE:
  - latch `wdata`, clear `uart_tx_int_flag`, go to START.
  - START drives 0 for `clk_per_bit` cycles.
  - DATA drives 8 bits LSB first, `clk_per_bit` cycles each.
  - STOP drives 1 for `clk_per_bit` cycles.
  - Then return to IDLE and set `uart_tx_int_flag`.
- TX write hit while not IDLE: acknowledged (ready pulses, bus never stalls), data discarded, frame in progress unaffected.
- `uart_tx_int_flag` stays set until the next accepted write in IDLE.

RX FSM (IDLE, START, DATA, STOP):
- `rx_uart` passes through a 2-FF synchronizer.
- IDLE: on a synchronized falling edge, go to START.
- START: wait `clk_per_bit`/2 cycles, then resample. If high (glitch), return to IDLE; if low, go to DATA.
- DATA: sample 8 bits every `clk_per_bit` cycles (bit centres), shifting in LSB first.
- STOP: sample once after `clk_per_bit`.
  - If 1: load `data_out`, set `uart_rx_int_flag`.
  - If 0 (framing error): discard the byte, leave the flag unchanged.
  - Either way, return to IDLE.
- `data_out` holds its value until the next good frame. Reads do not alter it.
- An RX read hit clears `uart_rx_int_flag` (on the same edge that raises `uart_rx_ready`). Reads are acknowledged even when the flag is clear.
- Simultaneous flag set (frame completion) and clear (read hit) in one cycle: set wins.
- Overrun: a new good frame overwrites `data_out`; the flag stays set.

## Timing
- Bus hit at rising edge k → ready high during cycle k+1 only.
- TX: `tx_uart` goes low at the edge after the write hit. The frame lasts exactly 10×`clk_per_bit` cycles. `uart_tx_int_flag` rises at the end of the stop bit.
- RX: `uart_rx_int_flag` and `data_out` update about 9.5×`clk_per_bit` + 3 cycles after the falling edge on `rx_uart`.
- Bit counters are 12 bits wide, load `clk_per_bit`-1, and count to 0. Integer halving of `clk_per_bit`; ±1-cycle sampling error tolerated.

## Test plan
- Reset: assert `rstn`=1 for 2 cycles → `tx_uart`=1, all flags and readies 0, `data_out`=00.
- Loopback (`tx_uart`→`rx_uart`), `clk_per_bit`=1666: write 8'hAF to `TX_ADDR` with `mem_valid` held 2 cycles →
  - `uart_tx_ready` pulses once.
  - Line shows 0,1,1,1,1,0,1,0,1,1 at 1666-cycle bits.
  - Both flags set; `data_out`=AF.
- Read `RX_ADDR` with `wstrobe`=0 → `uart_rx_ready` pulses once, `uart_rx_int_flag` clears, `data_out` stays AF.
- Second loopback of 8'hEE → `data_out`=EE; a write to `TX_ADDR` clears `uart_tx_int_flag` until its frame ends.
- Write 8'h55 during an active frame → acknowledged; line carries only the original byte.
- Start-bit glitch (low 100 cycles) → no flag set; corrupted stop bit (0) → `data_out` unchanged, flag unchanged; access to `addr`=0 → no ready.
